axi_lite_arbiter: RTL and testbench

//  Shares one downstream AXI4-Lite slave port among NUM_MASTERS upstream masters (e.g. IFU + LSU).

---
 rtl/axi_lite_if.sv | 31 +++
 rtl/axi_lite_arbiter.sv | 131 +++++++++++++
 tb/tb_axi_lite_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/axi_lite_if.sv
// axi_lite_if: AXI4-Lite channel bundle; master drives requests, slave drives readys and responses
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wmask;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wmask, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wmask, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_arbiter.sv
// axi_lite_arbiter: whole-transaction arbiter sharing one AXI4-Lite slave among NUM_MASTERS masters.
// Define ARBITER_RR_EN for round-robin; otherwise fixed priority (lowest index wins).
module axi_lite_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  axi_lite_if.slave                      m [NUM_MASTERS],
  axi_lite_if.master                     s,
  output logic                           busy,
  output logic [$clog2(NUM_MASTERS)-1:0] owner
);
  localparam int OW = $clog2(NUM_MASTERS);
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP} state_e;
  state_e state_q, state_d;
  logic [OW-1:0] owner_q, owner_d, win;
  logic aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [NUM_MASTERS-1:0] req, m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready;
  logic [ADDR_WIDTH-1:0] m_araddr [NUM_MASTERS];
  logic [ADDR_WIDTH-1:0] m_awaddr [NUM_MASTERS];
  logic [DATA_WIDTH-1:0] m_wdata [NUM_MASTERS];
  logic [DATA_WIDTH/8-1:0] m_wmask [NUM_MASTERS];
  logic run, rd_a, rd_d, wr_a, wr_r, ar_fire, r_fire, aw_fire, w_fire, b_fire;
  // Every forwarded valid/ready is qualified by state and forced low while reset is held
  assign run  = !reset;
  assign rd_a = run && state_q == RD_ADDR;
  assign rd_d = run && state_q == RD_DATA;
  assign wr_a = run && state_q == WR_ADDR;
  assign wr_r = run && state_q == WR_RESP;
  assign req  = m_arvalid | m_awvalid;
  assign busy  = run && state_q != IDLE;
  assign owner = owner_q;
  assign s.arvalid = rd_a && m_arvalid[owner_q];
  assign s.araddr  = m_araddr[owner_q];
  assign s.rready  = rd_d && m_rready[owner_q];
  assign s.awvalid = wr_a && !aw_done_q && m_awvalid[owner_q];
  assign s.awaddr  = m_awaddr[owner_q];
  assign s.wvalid  = wr_a && !w_done_q && m_wvalid[owner_q];
  assign s.wdata   = m_wdata[owner_q];
  assign s.wmask   = m_wmask[owner_q];
  assign s.bready  = wr_r && m_bready[owner_q];
  assign ar_fire = s.arvalid && s.arready;
  assign r_fire  = s.rvalid && s.rready;
  assign aw_fire = s.awvalid && s.awready;
  assign w_fire  = s.wvalid && s.wready;
  assign b_fire  = s.bvalid && s.bready;
  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_m
    logic own;
    assign own          = owner_q == OW'(i);
    assign m_arvalid[i] = m[i].arvalid;
    assign m_awvalid[i] = m[i].awvalid;
    assign m_wvalid[i]  = m[i].wvalid;
    assign m_rready[i]  = m[i].rready;
    assign m_bready[i]  = m[i].bready;
    assign m_araddr[i]  = m[i].araddr;
    assign m_awaddr[i]  = m[i].awaddr;
    assign m_wdata[i]   = m[i].wdata;
    assign m_wmask[i]   = m[i].wmask;
    assign m[i].arready = own && rd_a && s.arready;
    assign m[i].rvalid  = own && rd_d && s.rvalid;
    assign m[i].rdata   = s.rdata;
    assign m[i].rresp   = s.rresp;
    assign m[i].awready = own && wr_a && !aw_done_q && s.awready;
    assign m[i].wready  = own && wr_a && !w_done_q && s.wready;
    assign m[i].bvalid  = own && wr_r && s.bvalid;
    assign m[i].bresp   = s.bresp;
  end
`ifdef ARBITER_RR_EN
  logic [OW-1:0] last_q;
  int dist, best;
  // Distance from last_grant+1 ranks the requesters; smallest distance wins
  always_comb begin
    win  = '0;
    best = NUM_MASTERS;
    dist = 0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      dist = (j + NUM_MASTERS - 1 - int'(last_q)) % NUM_MASTERS;
      if (req[j] && dist < best) begin
        best = dist;
        win  = OW'(j);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) last_q <= OW'(NUM_MASTERS - 1);
    else if (state_q == IDLE && |req) last_q <= win;
  end
`else
  always_comb begin
    win = '0;
    for (int j = NUM_MASTERS - 1; j >= 0; j--)
      if (req[j]) win = OW'(j);
  end
`endif
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    aw_done_d = aw_done_q | aw_fire;
    w_done_d  = w_done_q | w_fire;
    case (state_q)
      IDLE: if (|req) begin
        owner_d = win;
        state_d = m_arvalid[win] ? RD_ADDR : WR_ADDR;
      end
      RD_ADDR: state_d = ar_fire ? RD_DATA : RD_ADDR;
      RD_DATA: state_d = r_fire ? IDLE : RD_DATA;
      WR_ADDR: if (aw_done_d && w_done_d) begin
        state_d   = WR_RESP;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
      end
      WR_RESP: state_d = b_fire ? IDLE : WR_RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb_axi_lite_arbiter: directed scenarios for the two-master AXI4-Lite arbiter
module tb_axi_lite_arbiter;
`ifdef ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk, reset, busy;
  logic [0:0] owner;
  int pass = 0, total = 0;
  axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mi [2] ();
  axi_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) si ();
  axi_lite_arbiter #(.NUM_MASTERS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .m(mi), .s(si), .busy(busy), .owner(owner)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic idle_all();
    mi[0].arvalid = 0; mi[0].araddr = '0; mi[0].rready = 1; mi[0].awvalid = 0; mi[0].awaddr = '0;
    mi[0].wvalid = 0; mi[0].wdata = '0; mi[0].wmask = '0; mi[0].bready = 1;
    mi[1].arvalid = 0; mi[1].araddr = '0; mi[1].rready = 1; mi[1].awvalid = 0; mi[1].awaddr = '0;
    mi[1].wvalid = 0; mi[1].wdata = '0; mi[1].wmask = '0; mi[1].bready = 1;
    si.arready = 0; si.rvalid = 0; si.rdata = '0; si.rresp = '0;
    si.awready = 0; si.wready = 0; si.bvalid = 0; si.bresp = '0;
  endtask
  task automatic rst_pulse();
    @(posedge clk); #1; reset = 1; idle_all();
    @(posedge clk); #1; reset = 0;
  endtask
  task automatic test_reset();
    reset = 1;
    mi[0].arvalid = 1; mi[0].awvalid = 1; mi[0].wvalid = 1;
    mi[1].arvalid = 1; mi[1].awvalid = 1; mi[1].wvalid = 1;
    si.arready = 1; si.awready = 1; si.wready = 1; si.rvalid = 1; si.bvalid = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if ({si.arvalid, si.awvalid, si.wvalid, si.rready, si.bready} !== 5'b0) $display("FAIL rst_s_valids got %b exp 00000", {si.arvalid, si.awvalid, si.wvalid, si.rready, si.bready}); else pass++;
    total++; if ({mi[0].arready, mi[0].awready, mi[0].wready, mi[0].rvalid, mi[0].bvalid, mi[1].arready, mi[1].awready, mi[1].wready, mi[1].rvalid, mi[1].bvalid} !== 10'b0)
      $display("FAIL rst_m_readys got %b exp 0", {mi[0].arready, mi[0].awready, mi[0].wready, mi[0].rvalid, mi[0].bvalid, mi[1].arready, mi[1].awready, mi[1].wready, mi[1].rvalid, mi[1].bvalid}); else pass++;
    total++; if ({busy, owner} !== 2'b00) $display("FAIL rst_busy_owner got %b exp 00", {busy, owner}); else pass++;
    @(posedge clk); #1; idle_all(); reset = 0;
  endtask
  task automatic test_read_single();
    int bc;
    @(posedge clk); #1;
    mi[0].arvalid = 1; mi[0].araddr = 32'h8000_0000; si.arready = 1;
    @(negedge clk);
    total++; if ({busy, si.arvalid} !== 2'b00) $display("FAIL rd_idle_fwd got %b exp 00", {busy, si.arvalid}); else pass++;
    @(negedge clk);
    bc = busy;
    total++; if ({si.arvalid, mi[0].arready, mi[1].arready} !== 3'b110) $display("FAIL rd_ar_hs got %b exp 110", {si.arvalid, mi[0].arready, mi[1].arready}); else pass++;
    total++; if (si.araddr !== 32'h8000_0000) $display("FAIL rd_araddr got %h exp 80000000", si.araddr); else pass++;
    @(posedge clk); #1; mi[0].arvalid = 0; si.arready = 0;
    @(negedge clk); bc += busy;
    total++; if (mi[0].rvalid !== 1'b0) $display("FAIL rd_rvalid_early got %b exp 0", mi[0].rvalid); else pass++;
    @(posedge clk); #1; si.rvalid = 1; si.rdata = 32'hdead_beef;
    @(negedge clk); bc += busy;
    total++; if ({mi[0].rvalid, mi[1].rvalid, si.rready} !== 3'b101) $display("FAIL rd_r_hs got %b exp 101", {mi[0].rvalid, mi[1].rvalid, si.rready}); else pass++;
    total++; if (mi[0].rdata !== 32'hdead_beef) $display("FAIL rd_rdata got %h exp deadbeef", mi[0].rdata); else pass++;
    @(posedge clk); #1; si.rvalid = 0;
    @(negedge clk); bc += busy;
    total++; if (bc !== 3) $display("FAIL rd_busy_cycles got %0d exp 3", bc); else pass++;
    rst_pulse();
  endtask
  task automatic test_arbitration();
    int n;
    bit seen1;
    logic g [4];
    logic [31:0] a [4];
    n = 0; seen1 = 0;
    @(posedge clk); #1;
    mi[0].arvalid = 1; mi[0].araddr = 32'h100; mi[1].arvalid = 1; mi[1].araddr = 32'h200;
    si.arready = 1; si.rvalid = 1; si.rdata = 32'h55;
    for (int c = 0; c < 30 && n < 4; c++) begin
      @(negedge clk);
      if (mi[1].arready) seen1 = 1;
      if (si.arvalid) begin g[n] = owner; a[n] = si.araddr; n++; end
    end
    total++; if (n !== 4) $display("FAIL arb_grant_count got %0d exp 4", n); else pass++;
    for (int k = 0; k < 4; k++) begin
      logic eg;
      eg = RR ? k[0] : 1'b0;
      total++; if (g[k] !== eg) $display("FAIL arb_grant%0d got %b exp %b", k, g[k], eg); else pass++;
      total++; if (a[k] !== (eg ? 32'h200 : 32'h100)) $display("FAIL arb_addr%0d got %h exp %h", k, a[k], eg ? 32'h200 : 32'h100); else pass++;
    end
    total++; if (seen1 !== RR) $display("FAIL arb_m1_arready got %b exp %b", seen1, RR); else pass++;
    rst_pulse();
  endtask
  task automatic test_write_w_first();
    @(posedge clk); #1;
    mi[1].wvalid = 1; mi[1].wdata = 32'h41; mi[1].wmask = 4'h1; mi[1].awaddr = 32'ha000_03f8;
    si.wready = 1; si.awready = 0;
    @(negedge clk);
    total++; if ({busy, si.wvalid} !== 2'b00) $display("FAIL wr_w_only got %b exp 00", {busy, si.wvalid}); else pass++;
    @(posedge clk); #1;
    @(posedge clk); #1; mi[1].awvalid = 1;
    @(posedge clk);
    @(negedge clk);
    total++; if ({owner, si.awvalid, si.wvalid, mi[1].wready, mi[1].awready, mi[0].wready} !== 6'b111100) $display("FAIL wr_first got %b exp 111100", {owner, si.awvalid, si.wvalid, mi[1].wready, mi[1].awready, mi[0].wready}); else pass++;
    total++; if ({si.awaddr, si.wdata, si.wmask} !== {32'ha000_03f8, 32'h41, 4'h1}) $display("FAIL wr_payload got %h %h %h exp a00003f8 00000041 1", si.awaddr, si.wdata, si.wmask); else pass++;
    @(posedge clk);
    @(negedge clk);
    total++; if ({si.wvalid, mi[1].wready, si.awvalid} !== 3'b001) $display("FAIL wr_w_done got %b exp 001", {si.wvalid, mi[1].wready, si.awvalid}); else pass++;
    @(posedge clk); #1; si.awready = 1;
    @(negedge clk);
    total++; if ({si.wvalid, mi[1].awready, busy} !== 3'b011) $display("FAIL wr_aw_late got %b exp 011", {si.wvalid, mi[1].awready, busy}); else pass++;
    @(posedge clk); #1;
    mi[1].awvalid = 0; mi[1].wvalid = 0; si.bvalid = 1; si.bresp = 2'b01;
    @(negedge clk);
    total++; if ({mi[1].bvalid, mi[0].bvalid, si.bready, si.awvalid, si.wvalid} !== 5'b10100) $display("FAIL wr_b got %b exp 10100", {mi[1].bvalid, mi[0].bvalid, si.bready, si.awvalid, si.wvalid}); else pass++;
    total++; if (mi[1].bresp !== 2'b01) $display("FAIL wr_bresp got %b exp 01", mi[1].bresp); else pass++;
    @(posedge clk); #1; si.bvalid = 0;
    @(negedge clk);
    total++; if ({busy, mi[1].bvalid} !== 2'b00) $display("FAIL wr_done got %b exp 00", {busy, mi[1].bvalid}); else pass++;
    rst_pulse();
  endtask
  task automatic test_rready_stall();
    @(posedge clk); #1;
    mi[0].arvalid = 1; mi[0].araddr = 32'h1000; mi[0].rready = 0; si.arready = 1;
    @(posedge clk); #1; mi[1].arvalid = 1; mi[1].araddr = 32'h2000;
    @(posedge clk); #1; mi[0].arvalid = 0; si.arready = 0; si.rvalid = 1; si.rdata = 32'h1234_5678;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++; if (si.rready !== 1'b0) $display("FAIL stall_rready%0d got %b exp 0", k, si.rready); else pass++;
      total++; if ({owner, mi[1].arready, mi[0].rvalid, busy} !== 4'b0011) $display("FAIL stall_hold%0d got %b exp 0011", k, {owner, mi[1].arready, mi[0].rvalid, busy}); else pass++;
      @(posedge clk); #1;
    end
    mi[0].rready = 1;
    @(negedge clk);
    total++; if ({si.rready, mi[0].rdata} !== {1'b1, 32'h1234_5678}) $display("FAIL stall_release got %b %h exp 1 12345678", si.rready, mi[0].rdata); else pass++;
    @(posedge clk); #1; si.rvalid = 0;
    @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL stall_idle got %b exp 0", busy); else pass++;
    @(posedge clk);
    @(negedge clk);
    total++; if ({owner, si.arvalid, si.araddr} !== {2'b11, 32'h2000}) $display("FAIL stall_next got %b %b %h exp 1 1 00002000", owner, si.arvalid, si.araddr); else pass++;
    rst_pulse();
  endtask
  task automatic test_reset_wr_resp();
    @(posedge clk); #1;
    mi[0].awvalid = 1; mi[0].awaddr = 32'h40; mi[0].wvalid = 1; mi[0].wdata = 32'h99; mi[0].wmask = 4'hf; mi[0].bready = 0;
    si.awready = 1; si.wready = 1; si.bvalid = 1;
    @(posedge clk); #1;
    @(posedge clk); #1; mi[0].awvalid = 0; mi[0].wvalid = 0;
    @(negedge clk);
    total++; if ({busy, mi[0].bvalid, si.bready} !== 3'b110) $display("FAIL rwr_in_resp got %b exp 110", {busy, mi[0].bvalid, si.bready}); else pass++;
    @(posedge clk); #1; reset = 1; mi[0].bready = 1;
    @(posedge clk); #1; reset = 0;
    @(negedge clk);
    total++; if ({busy, si.bready, mi[0].bvalid, mi[1].bvalid, owner} !== 5'b0) $display("FAIL rwr_after_rst got %b exp 00000", {busy, si.bready, mi[0].bvalid, mi[1].bvalid, owner}); else pass++;
    @(posedge clk); #1; idle_all(); mi[1].arvalid = 1; mi[1].araddr = 32'h300;
    @(posedge clk);
    @(negedge clk);
    total++; if ({owner, si.arvalid, busy} !== 3'b111) $display("FAIL rwr_new_grant got %b exp 111", {owner, si.arvalid, busy}); else pass++;
    rst_pulse();
  endtask
  initial begin
    reset = 1;
    idle_all();
    test_reset();
    test_read_single();
    test_arbitration();
    test_write_w_first();
    test_rready_stall();
    test_reset_wr_resp();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
